i2s_tdm_serializer: RTL and testbench

- Parametrised successor to the fixed 2-channel I2S output path of the S/PDIF receiver.
- Accepts one whole audio frame of parallel samples per valid/ready handshake.
- Generates bit clock, word select and serial data in one of four runtime formats: I2S, left-justified, right-justified or TDM.
- Sits between the sample source (decoder or test pattern) and the uo_out pins. Underrun is flagged and the frame is muted.

---
 rtl/toi2s_pkg.sv | 13 +
 rtl/i2s_tdm_serializer_bck_gen.sv | 47 ++++
 rtl/i2s_tdm_serializer.sv | 174 +++++++++++++++++
 tb/tb_i2s_tdm_serializer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/toi2s_pkg.sv
// Shared constants for the I2S/TDM serializer: output format codes and frame sizing.
package toi2s_pkg;

  localparam logic [1:0] MODE_I2S = 2'd0;
  localparam logic [1:0] MODE_LJ  = 2'd1;
  localparam logic [1:0] MODE_RJ  = 2'd2;
  localparam logic [1:0] MODE_TDM = 2'd3;

  function automatic int frame_bits(input int num_ch, input int slot_width);
    return num_ch * slot_width;
  endfunction

endpackage

// File: rtl/i2s_tdm_serializer_bck_gen.sv
// Bit-clock divider: bck toggles every BCK_DIV clocks while enabled; fall marks the
// cycle whose closing edge drives bck from 1 to 0.
module bck_gen #(
  parameter int BCK_DIV = 2
) (
  input  logic clk_in,
  input  logic resetb,
  input  logic enable,
  output logic bck,
  output logic fall
);

  localparam int CW = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;

  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic          bck_q, bck_d;
  logic          tc;

  always_comb begin
    tc        = (div_cnt_q == CW'(BCK_DIV - 1));
    div_cnt_d = div_cnt_q;
    bck_d     = bck_q;
    if (!enable) begin
      div_cnt_d = '0;
      bck_d     = 1'b0;
    end else if (tc) begin
      div_cnt_d = '0;
      bck_d     = ~bck_q;
    end else begin
      div_cnt_d = div_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge resetb) begin
    if (!resetb) begin
      div_cnt_q <= '0;
      bck_q     <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bck_q     <= bck_d;
    end
  end

  assign bck  = bck_q;
  assign fall = enable & tc & bck_q;

endmodule

// File: rtl/i2s_tdm_serializer.sv
// Frame-at-a-time audio serializer: one-deep holding buffer, frame shifter and a
// formatter producing I2S, left-/right-justified or TDM on registered pins.
module i2s_tdm_serializer
  import toi2s_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 24,
  parameter int SLOT_WIDTH   = 32,
  parameter int NUM_CH       = 2,
  parameter int BCK_DIV      = 2
) (
  input  logic                           clk_in,
  input  logic                           resetb,
  input  logic                           enable,
  input  logic [1:0]                     mode,
  input  logic [NUM_CH*SAMPLE_WIDTH-1:0] in_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic                           i2s_bck,
  output logic                           i2s_ws,
  output logic                           i2s_d0,
  output logic                           frame_start,
  output logic                           underrun
);

  localparam int FRAME_BITS = frame_bits(NUM_CH, SLOT_WIDTH);
  localparam int DATA_W     = NUM_CH * SAMPLE_WIDTH;
  localparam int FB_W       = $clog2(FRAME_BITS);
  localparam int K_W        = (SLOT_WIDTH > 1) ? $clog2(SLOT_WIDTH) : 1;
  localparam int S_W        = $clog2(NUM_CH);
  localparam int RJ_PAD     = SLOT_WIDTH - SAMPLE_WIDTH;

  logic              fall;
  logic [1:0]        mode_q, mode_d, eff_mode;
  logic              started_q, started_d;
  logic [FB_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [K_W-1:0]    k_q, k_d;
  logic [S_W-1:0]    slot_q, slot_d;
  logic [DATA_W-1:0] hold_q, hold_d, hold_order;
  logic              hold_full_q, hold_full_d;
  logic [DATA_W-1:0] shift_q, shift_d, src;
  logic              delay_q, delay_d;
  logic              ws_q, ws_d, d0_q, d0_d;
  logic              frame_start_q, frame_start_d, underrun_q, underrun_d;
  logic              boundary, consume, raw_bit;

  bck_gen #(.BCK_DIV(BCK_DIV)) u_bck_gen (
    .clk_in (clk_in),
    .resetb (resetb),
    .enable (enable),
    .bck    (i2s_bck),
    .fall   (fall)
  );

  // Shifter holds channel 0 in its MSBs so samples leave in channel order.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_order
    assign hold_order[(NUM_CH-1-gi)*SAMPLE_WIDTH +: SAMPLE_WIDTH] =
      hold_q[gi*SAMPLE_WIDTH +: SAMPLE_WIDTH];
  end

  always_comb begin
    eff_mode  = (NUM_CH != 2) ? MODE_TDM : mode_q;
    mode_d    = enable ? mode_q : mode;
    started_d = started_q;
    bit_cnt_d = bit_cnt_q;
    k_d       = k_q;
    slot_d    = slot_q;
    boundary  = 1'b0;
    if (!enable) begin
      started_d = 1'b0;
      bit_cnt_d = '0;
      k_d       = '0;
      slot_d    = '0;
    end else if (fall) begin
      started_d = 1'b1;
      if (!started_q || bit_cnt_q == FB_W'(FRAME_BITS - 1)) begin
        boundary  = 1'b1;
        bit_cnt_d = '0;
        k_d       = '0;
        slot_d    = '0;
      end else begin
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (k_q == K_W'(SLOT_WIDTH - 1)) begin
          k_d    = '0;
          slot_d = slot_q + 1'b1;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
    end

    // Only sample-carrying slot positions consume a shifter bit; padding sends 0.
    src     = boundary ? (hold_full_q ? hold_order : '0) : shift_q;
    consume = (eff_mode == MODE_RJ) ? (int'(k_d) >= RJ_PAD) : (int'(k_d) < SAMPLE_WIDTH);
    raw_bit = consume & src[DATA_W-1];

    shift_d = shift_q;
    delay_d = delay_q;
    ws_d    = ws_q;
    d0_d    = d0_q;
    if (!enable) begin
      delay_d = 1'b0;
      ws_d    = 1'b0;
      d0_d    = 1'b0;
    end else if (fall) begin
      shift_d = consume ? (src << 1) : src;
      delay_d = raw_bit;
      case (eff_mode)
        MODE_I2S: begin
          ws_d = (slot_d == S_W'(1));
          d0_d = delay_q;
        end
        MODE_LJ, MODE_RJ: begin
          ws_d = (slot_d == '0);
          d0_d = raw_bit;
        end
        default: begin
          ws_d = (bit_cnt_d == '0);
          d0_d = delay_q;
        end
      endcase
    end

    frame_start_d = boundary;
    underrun_d    = boundary & ~hold_full_q;

    // The buffer is released the cycle after frame_start, so in_ready rises one cycle later.
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    if (frame_start_q && !underrun_q) hold_full_d = 1'b0;
    if (in_valid && !hold_full_q) begin
      hold_d      = in_data;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge resetb) begin
    if (!resetb) begin
      mode_q        <= '0;
      started_q     <= 1'b0;
      bit_cnt_q     <= '0;
      k_q           <= '0;
      slot_q        <= '0;
      hold_q        <= '0;
      hold_full_q   <= 1'b0;
      shift_q       <= '0;
      delay_q       <= 1'b0;
      ws_q          <= 1'b0;
      d0_q          <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      mode_q        <= mode_d;
      started_q     <= started_d;
      bit_cnt_q     <= bit_cnt_d;
      k_q           <= k_d;
      slot_q        <= slot_d;
      hold_q        <= hold_d;
      hold_full_q   <= hold_full_d;
      shift_q       <= shift_d;
      delay_q       <= delay_d;
      ws_q          <= ws_d;
      d0_q          <= d0_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
    end
  end

  assign in_ready    = ~hold_full_q;
  assign i2s_ws      = ws_q;
  assign i2s_d0      = d0_q;
  assign frame_start = frame_start_q;
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_i2s_tdm_serializer.sv
// Bench for i2s_tdm_serializer: a 2-channel default instance and a 4-channel TDM instance,
// compared cycle by cycle against a frame-level reference model.
module tb_i2s_tdm_serializer;

  localparam int D  = 2;   // clk cycles per bck half-period
  localparam int FB = 64;  // bck cycles per frame in both configurations

  logic        clk = 1'b0;
  logic        resetb, en, sel, in_valid;
  logic [1:0]  mode_in;
  logic [63:0] in_data;

  logic bck0, ws0, d00, fs0, ur0, rdy0;
  logic bck1, ws1, d01, fs1, ur1, rdy1;
  logic o_bck, o_ws, o_d0, o_fs, o_ur, o_ready;

  always #5 clk = ~clk;

  i2s_tdm_serializer dut (
    .clk_in(clk), .resetb(resetb), .enable(en & ~sel), .mode(mode_in),
    .in_data(in_data[47:0]), .in_valid(in_valid & ~sel), .in_ready(rdy0),
    .i2s_bck(bck0), .i2s_ws(ws0), .i2s_d0(d00), .frame_start(fs0), .underrun(ur0)
  );

  i2s_tdm_serializer #(.SAMPLE_WIDTH(16), .SLOT_WIDTH(16), .NUM_CH(4), .BCK_DIV(2)) dut_tdm (
    .clk_in(clk), .resetb(resetb), .enable(en & sel), .mode(mode_in),
    .in_data(in_data), .in_valid(in_valid & sel), .in_ready(rdy1),
    .i2s_bck(bck1), .i2s_ws(ws1), .i2s_d0(d01), .frame_start(fs1), .underrun(ur1)
  );

  assign o_bck   = sel ? bck1 : bck0;
  assign o_ws    = sel ? ws1  : ws0;
  assign o_d0    = sel ? d01  : d00;
  assign o_fs    = sel ? fs1  : fs0;
  assign o_ur    = sel ? ur1  : ur0;
  assign o_ready = sel ? rdy1 : rdy0;

  int          n_assert, n_fail;
  int          c;              // enabled clock edges since enable rose
  bit          mdl_full, rel_pend;
  logic [63:0] mdl_hold;
  logic [1:0]  mdl_mode;
  logic [63:0] src_q[$];
  logic [63:0] played_q[$];
  logic [63:0] ws_cap, d0_cap;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] mk2(input logic [23:0] l, input logic [23:0] r);
    return {16'h0, r, l};
  endfunction

  function automatic logic [63:0] mk4(input logic [15:0] a, input logic [15:0] b,
                                      input logic [15:0] cc, input logic [15:0] d);
    return {d, cc, b, a};
  endfunction

  // Raw slot bit at frame position p, straight from the slot layout rules.
  function automatic bit raw_bit(input logic [63:0] fr, input int p, input int md, input bit s);
    int slot, samp, ch, k, pos;
    logic [63:0] t;
    slot = s ? 16 : 32;
    samp = s ? 16 : 24;
    ch   = p / slot;
    k    = p % slot;
    pos  = (md == 2) ? k - (slot - samp) : k;
    if (pos < 0 || pos >= samp) return 1'b0;
    t = fr >> (ch * samp + samp - 1 - pos);
    return t[0];
  endfunction

  function automatic bit ws_exp(input int p, input int md, input bit s);
    int ch;
    ch = p / (s ? 16 : 32);
    case (md)
      0:       return ch == 1;
      1, 2:    return ch == 0;
      default: return p == 0;
    endcase
  endfunction

  task automatic check_frame(input int f);
    int md;
    bit prev, b;
    logic [63:0] we, de;
    md   = sel ? 3 : int'(mdl_mode);
    prev = (f == 0) ? 1'b0 : raw_bit(played_q[f-1], FB - 1, md, sel);
    we = '0;
    de = '0;
    for (int q = 0; q < FB; q++) begin
      if (md == 0 || md == 3) b = (q == 0) ? prev : raw_bit(played_q[f], q - 1, md, sel);
      else                    b = raw_bit(played_q[f], q, md, sel);
      we = {we[62:0], ws_exp(q, md, sel)};
      de = {de[62:0], b};
    end
    check($sformatf("ws frame %0d mode %0d", f, md), ws_cap, we);
    check($sformatf("d0 frame %0d mode %0d", f, md), d0_cap, de);
  endtask

  // One clock: offer/handshake, model update at the edge, output checks half a cycle later.
  task automatic step();
    bit rdy_pre, acc, bnd, fs_e, ur_e;
    int m, p;
    in_valid = (src_q.size() > 0);
    if (in_valid) in_data = src_q[0];
    rdy_pre = !mdl_full;
    check("in_ready", 64'(o_ready), 64'(rdy_pre));
    acc = in_valid && rdy_pre;
    @(posedge clk);
    fs_e = 1'b0;
    ur_e = 1'b0;
    if (rel_pend) begin
      mdl_full = 1'b0;
      rel_pend = 1'b0;
    end
    if (!en) begin
      c        = 0;
      mdl_mode = mode_in;
    end else begin
      c++;
      bnd = (c >= 2 * D) && ((c - 2 * D) % (FB * 2 * D) == 0);
      if (bnd) begin
        played_q.push_back(mdl_full ? mdl_hold : 64'h0);
        fs_e = 1'b1;
        ur_e = !mdl_full;
        if (mdl_full) rel_pend = 1'b1;
      end
    end
    if (acc) begin
      mdl_full = 1'b1;
      mdl_hold = src_q.pop_front();
    end
    @(negedge clk);
    check("bck", 64'(o_bck), 64'(en ? (c / D) % 2 : 0));
    check("frame_start", 64'(o_fs), 64'(fs_e));
    check("underrun", 64'(o_ur), 64'(ur_e));
    if (en && c >= D && (c % (2 * D)) == D) begin
      m = c / (2 * D);
      if (m == 0) begin
        check("ws before first frame", 64'(o_ws), 64'h0);
        check("d0 before first frame", 64'(o_d0), 64'h0);
      end else begin
        p = (m - 1) % FB;
        ws_cap = {ws_cap[62:0], o_ws};
        d0_cap = {d0_cap[62:0], o_d0};
        if (p == FB - 1) check_frame((m - 1) / FB);
      end
    end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " bck"}, 64'(o_bck), 64'h0);
    check({tag, " ws"}, 64'(o_ws), 64'h0);
    check({tag, " d0"}, 64'(o_d0), 64'h0);
    check({tag, " frame_start"}, 64'(o_fs), 64'h0);
    check({tag, " underrun"}, 64'(o_ur), 64'h0);
    check({tag, " in_ready"}, 64'(o_ready), 64'h1);
  endtask

  task automatic phase_start(input bit s, input logic [1:0] md);
    en = 1'b0;
    in_valid = 1'b0;
    src_q.delete();
    played_q.delete();
    sel = s;
    mode_in = md;
    resetb = 1'b0;
    repeat (2) @(negedge clk);
    resetb = 1'b1;
    c = 0;
    mdl_full = 1'b0;
    rel_pend = 1'b0;
    mdl_mode = 2'd0;
    run(2);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    resetb = 1'b0; en = 1'b0; sel = 1'b0; in_valid = 1'b0; in_data = '0; mode_in = 2'd0;
    ws_cap = '0; d0_cap = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset dut");
    sel = 1'b1;
    check_reset_outputs("reset dut_tdm");

    // I2S: known frame then random ones; runs out into an underrun, then reset mid-frame.
    phase_start(1'b0, 2'd0);
    src_q.push_back(mk2(24'hA5A5A5, 24'h5A5A5A));
    repeat (3) src_q.push_back(mk2(24'($urandom), 24'($urandom)));
    run(6);
    en = 1'b1;
    run(4 * FB * 2 * D + 100);
    resetb = 1'b0;
    #1;
    check_reset_outputs("mid-run reset");

    // Left-justified; a mode change while enabled must be ignored.
    phase_start(1'b0, 2'd1);
    src_q.push_back(mk2(24'h800001, 24'($urandom)));
    src_q.push_back(mk2(24'($urandom), 24'($urandom)));
    src_q.push_back(mk2(24'($urandom), 24'h800001));
    run(4);
    en = 1'b1;
    run(FB * 2 * D);
    mode_in = 2'd0;
    run(2 * FB * 2 * D + 4);

    // Right-justified.
    phase_start(1'b0, 2'd2);
    src_q.push_back(mk2(24'h800001, 24'($urandom)));
    src_q.push_back(mk2(24'($urandom), 24'h000001));
    src_q.push_back(mk2(24'($urandom), 24'($urandom)));
    run(4);
    en = 1'b1;
    run(3 * FB * 2 * D + 4);

    // Four-channel instance with mode 0 requested: must still produce TDM.
    phase_start(1'b1, 2'd0);
    src_q.push_back(mk4(16'h8000, 16'h0001, 16'hFFFF, 16'h0000));
    src_q.push_back(mk4(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)));
    src_q.push_back(mk4(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)));
    run(4);
    en = 1'b1;
    run(3 * FB * 2 * D + 4);

    // Underrun and resume mid-frame.
    phase_start(1'b0, 2'd0);
    src_q.push_back(mk2(24'($urandom), 24'($urandom)));
    run(4);
    en = 1'b1;
    run(FB * 2 * D + 100);
    src_q.push_back(mk2(24'($urandom), 24'($urandom)));
    run(3 * FB * 2 * D - 96);

    // Continuous supply of an incrementing pattern.
    phase_start(1'b0, 2'd1);
    for (int i = 0; i < 8; i++) src_q.push_back(mk2(24'(16 * i + 1), 24'(16 * i + 2)));
    run(4);
    en = 1'b1;
    run(9 * FB * 2 * D + 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
